// File: rtl/fxp_addsub_writeback.sv
// Writeback stage behind the fixed-point adder/subtractor. It can saturate each result on
// overflow, queues the results in a small FIFO, and releases them over a valid/ready handshake.
// It also keeps a sticky overflow status bit.
module fxp_addsub_writeback #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned DEPTH      = 4,
  parameter bit          SATURATE   = 1'b1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_n,
  input  logic                  in_v,
  input  logic                  in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_n,
  output logic                  out_z,
  output logic                  out_sat,
  output logic                  sticky_v,
  input  logic                  sticky_clr,
  output logic [CW-1:0]         count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The Q-format is documentation only. The adder's N/Z flags are recomputed from stored data.
  localparam int unsigned unused_frac_bits = FRAC_BITS;
  logic unused_in_flags;
  assign unused_in_flags = in_n ^ in_z;

  // Each entry is {sat, data}.
  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [DATA_WIDTH:0] last_q;
  logic                sticky_q;

  logic                push, pop, sat_hit;
  logic [DATA_WIDTH:0] wr_entry, head;

  // Handshake decode. in_ready depends on occupancy only, so a full FIFO never admits a push.
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Clamp an overflowed result toward the side the true sum would have been on.
  always_comb begin
    sat_hit  = SATURATE & in_v;
    wr_entry = {1'b0, in_data};
    if (sat_hit) begin
      wr_entry = in_data[DATA_WIDTH-1] ? {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}}
                                       : {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  // Head of the queue. When the queue is empty, show the last popped entry.
  always_comb begin
    head     = out_valid ? mem_q[rd_ptr_q] : last_q;
    out_data = head[DATA_WIDTH-1:0];
    out_sat  = head[DATA_WIDTH];
    out_n    = head[DATA_WIDTH-1];
    out_z    = (head[DATA_WIDTH-1:0] == '0);
    count    = count_q;
    sticky_v = sticky_q;
  end

  // FIFO storage. It has no reset because the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Pointers, occupancy, hold register and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      // When a set and a clear land in the same cycle, the set wins.
      sticky_q <= (sticky_q & ~sticky_clr) | (push & in_v);
    end
  end

endmodule

// File: tb/tb_fxp_addsub_writeback.sv
// Directed bench for fxp_addsub_writeback using the default parameters (Q8.8, DEPTH=4, SATURATE=1).
module tb_fxp_addsub_writeback;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_n, in_v, in_z;
  logic        out_valid, out_ready, out_n, out_z, out_sat, sticky_v, sticky_clr;
  logic [15:0] in_data, out_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fails  = 0;

  fxp_addsub_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_n      (in_n),
    .in_v      (in_v),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_n     (out_n),
    .out_z     (out_z),
    .out_sat   (out_sat),
    .sticky_v  (sticky_v),
    .sticky_clr(sticky_clr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream must hold valid and data while it is stalled.
  logic        stall_prev = 1'b0;
  logic [15:0] data_prev  = '0;
  always @(posedge clk) begin
    if (!rst && stall_prev) check("proto_hold", {15'd0, in_valid, in_data}, {15'd0, 1'b1, data_prev});
    stall_prev <= in_valid & ~in_ready & ~rst;
    data_prev  <= in_data;
  end

  logic [15:0] q[$];
  logic        acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_n = 1'b0; in_v = 1'b0; in_z = 1'b0;
    out_ready = 1'b0; sticky_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_flags", {29'd0, out_n, out_z, out_sat}, 32'b010);
    check("rst_sticky", 32'(sticky_v), 0);

    // 1: a plain value passes through with a latency of one cycle.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h4B60;
    step(); in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h4B60);
    check("t1_flags", {29'd0, out_n, out_z, out_sat}, 32'b000);
    step();
    check("t1_popped", 32'(out_valid), 0);
    check("t1_hold", 32'(out_data), 32'h4B60);

    // 2: saturation in both directions.
    in_valid = 1'b1; in_v = 1'b1; in_data = 16'hFF40;
    step(); in_valid = 1'b0; in_v = 1'b0;
    check("t2_pos_data", 32'(out_data), 32'h7FFF);
    check("t2_pos_flags", {29'd0, out_n, out_z, out_sat}, 32'b001);
    check("t2_sticky", 32'(sticky_v), 1);
    step();
    in_valid = 1'b1; in_v = 1'b1; in_data = 16'h0040;
    step(); in_valid = 1'b0; in_v = 1'b0;
    check("t2_neg_data", 32'(out_data), 32'h8000);
    check("t2_neg_flags", {29'd0, out_n, out_z, out_sat}, 32'b101);
    step();

    // 3: fill the FIFO, stall the fifth entry, then drain in order.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = 16'(i << 8);
      if (i < 5) step();
    end
    step();
    check("t3_full_count", 32'(count), 4);
    check("t3_full_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    check("t3_no_bypass", 32'(in_ready), 0);
    for (int k = 1; k <= 5; k++) begin
      check("t3_order_valid", 32'(out_valid), 1);
      check("t3_order_data", 32'(out_data), 32'(k << 8));
      acc = in_valid & in_ready;
      step();
      if (acc) in_valid = 1'b0;
    end
    check("t3_empty", 32'(out_valid), 0);

    // 4: steady push and pop at occupancy 2 across several pointer wraps.
    out_ready = 1'b0; q.delete();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'hA000 + 16'(i); q.push_back(in_data);
      step();
    end
    check("t4_count2", 32'(count), 2);
    out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      in_data = 16'hA000 + 16'(i);
      check("t4_stream_data", 32'(out_data), 32'(q[0]));
      step();
      void'(q.pop_front()); q.push_back(in_data);
      check("t4_stream_count", 32'(count), 2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t4_drain_data", 32'(out_data), 32'(q[0]));
      void'(q.pop_front());
      step();
    end
    check("t4_drained", 32'(count), 0);

    // 5: sticky_v set/clear priority; in_v without a push is ignored.
    sticky_clr = 1'b1;
    step();
    check("t5_clr", 32'(sticky_v), 0);
    in_valid = 1'b1; in_v = 1'b1; in_data = 16'h1234;
    step(); in_valid = 1'b0;
    check("t5_set_wins", 32'(sticky_v), 1);
    in_v = 1'b0;
    step();
    check("t5_clr_alone", 32'(sticky_v), 0);
    sticky_clr = 1'b0; in_v = 1'b1;
    step(); in_v = 1'b0;
    check("t5_no_push", 32'(sticky_v), 0);

    // 6: a reset in mid-stream discards the queued entries.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_v = (i == 0); in_data = 16'h0100 * 16'(i + 1);
      step();
    end
    in_valid = 1'b0; in_v = 1'b0;
    check("t6_count3", 32'(count), 3);
    check("t6_sticky_pre", 32'(sticky_v), 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("t6_count", 32'(count), 0);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_sticky", 32'(sticky_v), 0);
    check("t6_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 16'h0000;
    step(); in_valid = 1'b0;
    check("t6_zero_valid", 32'(out_valid), 1);
    check("t6_zero_flags", {29'd0, out_n, out_z, out_sat}, 32'b010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
